// File: rtl/load_merge_unit_if.sv
// Load/response/writeback bundle for load_merge_unit.
// slave = merge unit side, master = pipeline/cache side.
interface load_merge_unit_if #(
   parameter int DEST_W = 5
);
   logic              flush;
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        req_op;
   logic [1:0]        req_alo;
   logic [31:0]       req_rt;
   logic [DEST_W-1:0] req_dest;
   logic              rsp_valid;
   logic [31:0]       rsp_data;
   logic              wb_valid;
   logic              wb_ready;
   logic [31:0]       wb_data;
   logic [3:0]        wb_we;
   logic [DEST_W-1:0] wb_dest;

   modport master (
      output flush, req_valid, req_op, req_alo, req_rt, req_dest,
      output rsp_valid, rsp_data, wb_ready,
      input  req_ready, wb_valid, wb_data, wb_we, wb_dest
   );

   modport slave (
      input  flush, req_valid, req_op, req_alo, req_rt, req_dest,
      input  rsp_valid, rsp_data, wb_ready,
      output req_ready, wb_valid, wb_data, wb_we, wb_dest
   );
endinterface

// File: rtl/load_merge_unit.sv
// Purpose: tracks in-order outstanding loads, aligns/merges returned words for writeback.
// Latency: rsp -> wb_valid next cycle (0 cycles with LOAD_MERGE_BYPASS_EN); wb_* held while wb_valid && !wb_ready.
// Backpressure: req_ready drops when live entries plus responses still to be dropped reach DEPTH.
module load_merge_unit #(
   parameter int DEPTH  = 4,
   parameter int DEST_W = 5
) (
   input logic              clk,
   input logic              resetn,
   load_merge_unit_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   logic [2:0]        op_q  [DEPTH];
   logic [1:0]        alo_q [DEPTH];
   logic [31:0]       rt_q  [DEPTH];
   logic [31:0]       dat_q [DEPTH];
   logic [DEST_W-1:0] dst_q [DEPTH];

   logic [PW-1:0] hd, tl, rp;
   logic [CW-1:0] live, pend, drop;

   logic              acc, fill, dump, fast, head_rdy, retire, load_out, byp;
   logic [31:0]       m;
   logic [35:0]       mrg;
   logic              wbv_r;
   logic [31:0]       wbd_r;
   logic [3:0]        wbw_r;
   logic [DEST_W-1:0] wbt_r;

   // Returns {we[3:0], data[31:0]}.
   function automatic logic [35:0] merge(input logic [2:0] op, input logic [1:0] a,
                                         input logic [31:0] r, input logic [31:0] w);
      logic [31:0] sh;
      logic [7:0]  b;
      logic [15:0] h;
      logic [35:0] res;
      sh  = w >> {a, 3'b000};
      b   = sh[7:0];
      h   = a[1] ? w[31:16] : w[15:0];
      res = {4'b1111, w};
      case (op)
         3'd1: begin
            case (a)
               2'd0:    res = {4'b1000, w[7:0],  r[23:0]};
               2'd1:    res = {4'b1100, w[15:0], r[15:0]};
               2'd2:    res = {4'b1110, w[23:0], r[7:0]};
               default: res = {4'b1111, w};
            endcase
         end
         3'd2: begin
            case (a)
               2'd0:    res = {4'b1111, w};
               2'd1:    res = {4'b0111, r[31:24], w[31:8]};
               2'd2:    res = {4'b0011, r[31:16], w[31:16]};
               default: res = {4'b0001, r[31:8],  w[31:24]};
            endcase
         end
         3'd3:    res = {4'b1111, {24{b[7]}}, b};
         3'd4:    res = {4'b1111, 24'd0, b};
         3'd5:    res = {4'b1111, {16{h[15]}}, h};
         3'd6:    res = {4'b1111, 16'd0, h};
         default: res = {4'b1111, w};
      endcase
      return res;
   endfunction

   assign bus.req_ready = !bus.flush && (({1'b0, live} + {1'b0, drop}) < DEPTH_W);

   assign acc  = bus.req_valid && bus.req_ready;
   // Responses for flushed loads are older than any live entry, so they are consumed first.
   assign dump = bus.rsp_valid && (drop != '0);
   assign fill = bus.rsp_valid && (drop == '0) && (pend != '0);
   // Response lands on the head entry itself: merge straight from rsp_data.
   assign fast     = fill && (live == pend);
   assign head_rdy = (live != pend) || fast;
   assign m        = fast ? bus.rsp_data : dat_q[hd];
   assign mrg      = merge(op_q[hd], alo_q[hd], rt_q[hd], m);
   assign retire   = head_rdy && (!wbv_r || bus.wb_ready) && !bus.flush;

`ifdef LOAD_MERGE_BYPASS_EN
   assign byp           = fast && !wbv_r && !bus.flush;
   assign bus.wb_valid  = wbv_r || byp;
   assign bus.wb_data   = wbv_r ? wbd_r : mrg[31:0];
   assign bus.wb_we     = wbv_r ? wbw_r : (byp ? mrg[35:32] : 4'd0);
   assign bus.wb_dest   = wbv_r ? wbt_r : (byp ? dst_q[hd] : '0);
`else
   assign byp           = 1'b0;
   assign bus.wb_valid  = wbv_r;
   assign bus.wb_data   = wbd_r;
   assign bus.wb_we     = wbw_r;
   assign bus.wb_dest   = wbt_r;
`endif

   assign load_out = retire && !(byp && bus.wb_ready);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hd   <= '0;
         tl   <= '0;
         rp   <= '0;
         live <= '0;
         pend <= '0;
         drop <= '0;
      end else if (bus.flush) begin
         hd   <= '0;
         tl   <= '0;
         rp   <= '0;
         live <= '0;
         pend <= '0;
         drop <= drop - CW'(dump) + pend - CW'(fill);
      end else begin
         if (acc)    tl <= tl + 1'b1;
         if (retire) hd <= hd + 1'b1;
         if (fill)   rp <= rp + 1'b1;
         live <= live + CW'(acc) - CW'(retire);
         pend <= pend + CW'(acc) - CW'(fill);
         drop <= drop - CW'(dump);
      end
   end

   always_ff @(posedge clk) begin
      if (acc) begin
         op_q[tl]  <= bus.req_op;
         alo_q[tl] <= bus.req_alo;
         rt_q[tl]  <= bus.req_rt;
         dst_q[tl] <= bus.req_dest;
      end
      if (fill) dat_q[rp] <= bus.rsp_data;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wbv_r <= 1'b0;
         wbd_r <= '0;
         wbw_r <= '0;
         wbt_r <= '0;
      end else if (bus.flush) begin
         wbv_r <= 1'b0;
         wbd_r <= '0;
         wbw_r <= '0;
         wbt_r <= '0;
      end else if (load_out) begin
         wbv_r <= 1'b1;
         wbd_r <= mrg[31:0];
         wbw_r <= mrg[35:32];
         wbt_r <= dst_q[hd];
      end else if (bus.wb_ready) begin
         wbv_r <= 1'b0;
      end
   end
endmodule

// File: tb/tb_load_merge_unit.sv
// Directed bench for load_merge_unit: merge table, full queue with stall, flush/drop, async reset.
module tb_load_merge_unit;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   tests = 0;
   int   fails = 0;

   load_merge_unit_if #(.DEST_W(5)) lif ();

   load_merge_unit #(.DEPTH(4), .DEST_W(5)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (lif.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one load, answer it next cycle with wb_ready=1, check the result and its drain.
   task automatic one_load(input string tag, input logic [2:0] op, input logic [1:0] alo,
                           input logic [31:0] rt, input logic [4:0] dest, input logic [31:0] rsp,
                           input logic [31:0] exp_d, input logic [3:0] exp_we);
      lif.req_valid = 1'b1;
      lif.req_op    = op;
      lif.req_alo   = alo;
      lif.req_rt    = rt;
      lif.req_dest  = dest;
      tick();
      lif.req_valid = 1'b0;
      lif.rsp_valid = 1'b1;
      lif.rsp_data  = rsp;
      tick();
      lif.rsp_valid = 1'b0;
      chk({tag, " valid"}, 36'(lif.wb_valid), 36'd1);
      chk({tag, " data"},  36'(lif.wb_data),  36'(exp_d));
      chk({tag, " we"},    36'(lif.wb_we),    36'(exp_we));
      chk({tag, " dest"},  36'(lif.wb_dest),  36'(dest));
      tick();
      chk({tag, " drained"}, 36'(lif.wb_valid), 36'd0);
   endtask

   initial begin
      lif.flush     = 1'b0;
      lif.req_valid = 1'b0;
      lif.req_op    = 3'd0;
      lif.req_alo   = 2'd0;
      lif.req_rt    = 32'd0;
      lif.req_dest  = 5'd0;
      lif.rsp_valid = 1'b0;
      lif.rsp_data  = 32'd0;
      lif.wb_ready  = 1'b1;

      tick();
      chk("rst req_ready", 36'(lif.req_ready), 36'd1);
      chk("rst wb_valid",  36'(lif.wb_valid),  36'd0);
      chk("rst wb_data",   36'(lif.wb_data),   36'd0);
      chk("rst wb_we",     36'(lif.wb_we),     36'd0);
      chk("rst wb_dest",   36'(lif.wb_dest),   36'd0);
      resetn = 1'b1;
      tick();

      one_load("lwl a1", 3'd1, 2'd1, 32'h11223344, 5'd3,  32'hAABBCCDD, 32'hCCDD3344, 4'b1100);
      one_load("lwr a2", 3'd2, 2'd2, 32'h11223344, 5'd4,  32'hAABBCCDD, 32'h1122AABB, 4'b0011);
      one_load("lb a3",  3'd3, 2'd3, 32'h0,        5'd5,  32'h80000000, 32'hFFFFFF80, 4'b1111);
      one_load("lhu a2", 3'd6, 2'd2, 32'h0,        5'd6,  32'hAABBCCDD, 32'h0000AABB, 4'b1111);
      one_load("lh a1",  3'd5, 2'd1, 32'h0,        5'd7,  32'h00008001, 32'hFFFF8001, 4'b1111);
      one_load("lbu a1", 3'd4, 2'd1, 32'h0,        5'd8,  32'h00008000, 32'h00000080, 4'b1111);
      one_load("lwl a0", 3'd1, 2'd0, 32'h11223344, 5'd9,  32'hAABBCCDD, 32'hDD223344, 4'b1000);
      one_load("lwr a3", 3'd2, 2'd3, 32'h11223344, 5'd10, 32'hAABBCCDD, 32'h112233AA, 4'b0001);
      one_load("op7",    3'd7, 2'd2, 32'h0,        5'd11, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111);

      // Fill the queue, then return all four responses into a stalled writeback.
      lif.wb_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         lif.req_valid = 1'b1;
         lif.req_op    = 3'd0;
         lif.req_alo   = 2'd0;
         lif.req_dest  = 5'(i);
         tick();
      end
      lif.req_valid = 1'b0;
      chk("full req_ready", 36'(lif.req_ready), 36'd0);
      tick();
      chk("full no rsp wb_valid", 36'(lif.wb_valid), 36'd0);
      for (int i = 1; i <= 4; i++) begin
         lif.rsp_valid = 1'b1;
         lif.rsp_data  = 32'(i) << 8;
         tick();
         chk("stall data", 36'(lif.wb_data), 36'h100);
         chk("stall dest", 36'(lif.wb_dest), 36'd1);
      end
      lif.rsp_valid = 1'b0;
      chk("ready after pop", 36'(lif.req_ready), 36'd1);
      tick();
      chk("stall hold valid", 36'(lif.wb_valid), 36'd1);
      chk("stall hold data",  36'(lif.wb_data),  36'h100);
      lif.wb_ready = 1'b1;
      for (int i = 2; i <= 4; i++) begin
         tick();
         chk("order data", 36'(lif.wb_data), 36'(32'(i) << 8));
         chk("order dest", 36'(lif.wb_dest), 36'(i));
      end
      tick();
      chk("order drained", 36'(lif.wb_valid), 36'd0);

      // Two outstanding, then flush with a concurrent request that must be refused.
      for (int i = 5; i <= 6; i++) begin
         lif.req_valid = 1'b1;
         lif.req_dest  = 5'(i);
         tick();
      end
      lif.req_dest = 5'd9;
      lif.flush    = 1'b1;
      #1;
      chk("flush req_ready", 36'(lif.req_ready), 36'd0);
      tick();
      lif.flush     = 1'b0;
      lif.req_valid = 1'b0;
      chk("post flush wb_valid", 36'(lif.wb_valid), 36'd0);
      for (int i = 0; i < 2; i++) begin
         lif.rsp_valid = 1'b1;
         lif.rsp_data  = 32'hBAD0BAD0;
         tick();
         chk("drop wb_valid", 36'(lif.wb_valid), 36'd0);
      end
      lif.rsp_valid = 1'b1;
      tick();
      lif.rsp_valid = 1'b0;
      chk("spurious rsp", 36'(lif.wb_valid), 36'd0);
      one_load("lw after flush", 3'd0, 2'd0, 32'h0, 5'd7, 32'h12345678, 32'h12345678, 4'b1111);

      // Asynchronous reset with a full pipeline.
      lif.wb_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         lif.req_valid = 1'b1;
         lif.req_dest  = 5'(i);
         tick();
      end
      lif.req_valid = 1'b0;
      lif.rsp_valid = 1'b1;
      lif.rsp_data  = 32'h000000AA;
      tick();
      lif.rsp_valid = 1'b0;
      chk("pre reset wb_valid", 36'(lif.wb_valid), 36'd1);
      resetn = 1'b0;
      #1;
      chk("async rst wb_valid",  36'(lif.wb_valid),  36'd0);
      chk("async rst req_ready", 36'(lif.req_ready), 36'd1);
      tick();
      resetn       = 1'b1;
      lif.wb_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("after reset wb_valid", 36'(lif.wb_valid), 36'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
